// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int DEFAULT_LOCK_TIMEOUT = 1024;

    // Width of a requester index; at least one bit so ports stay legal.
    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin first-set-bit finder: scans from last_i+1 upward, wrapping
// modulo NUM_REQ, and reports the first asserted request.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int GRANT_W = grant_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [GRANT_W-1:0] last_i,
    output logic               found_o,
    output logic [GRANT_W-1:0] idx_o
);

    logic [GRANT_W-1:0] cand;

    // Lowest rotation distance from last_i wins; last_i itself is checked last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GRANT_W'((int'(last_i) + k) % NUM_REQ);
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one UART transmit path.
//
// state | meaning
// IDLE  | no grant held; pick next requester, 1 cycle
// LOCK  | granted requester passes straight through to the UART
//
// Optional macro UART_ARB_TIMEOUT_EN: adds an idle counter that releases a
// grant after LOCK_TIMEOUT cycles without a transfer while the holder has
// nothing valid. Without it, only a last-byte transfer or reset releases.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int DATA_W       = 8,
    parameter  int LOCK_TIMEOUT = DEFAULT_LOCK_TIMEOUT,
    localparam int GRANT_W      = grant_w(NUM_REQ)
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_valid,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_ready,
    output logic [GRANT_W-1:0]        grant_id,
    output logic                      busy
);

    arb_state_t         state_q, state_d;
    logic [GRANT_W-1:0] grant_q, grant_d;
    logic [GRANT_W-1:0] last_q, last_d;
    logic               pick_found;
    logic [GRANT_W-1:0] pick_idx;
    logic               xfer;
    logic [DATA_W-1:0]  data_arr [NUM_REQ];

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_i   (req_valid),
        .last_i  (last_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign grant_id = grant_q;

    // Next-state, grant bookkeeping and the LOCK passthrough.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        busy      = 1'b0;
        xfer      = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = LOCK;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            LOCK: begin
                busy               = 1'b1;
                tx_valid           = req_valid[grant_q];
                tx_data            = data_arr[grant_q];
                req_ready[grant_q] = tx_ready;
                xfer               = tx_valid && tx_ready;
                if (xfer) begin
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d = '0;
`endif
                    // Completion takes precedence over a coincident timeout.
                    if (req_last[grant_q]) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                    end
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_MAX) begin
                    // Saturate; a held valid byte keeps the grant.
                    if (!req_valid[grant_q]) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and grant registers; reset drops any grant in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GRANT_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Idle-cycle counter for grant release.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4, DATA_W=8, LOCK_TIMEOUT=16).
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int LT      = 16;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic [1:0]  grant_id;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [7:0] sent_q[$];

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DATA_W       (DATA_W),
        .LOCK_TIMEOUT (LT)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (RST_N && tx_valid && tx_ready) sent_q.push_back(tx_data);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  v;
        logic [31:0] d;
        logic [3:0]  l;
        logic        rdy;
        logic        e_txv;
        logic [7:0]  e_txd;
        logic [3:0]  e_rr;
        logic        e_busy;
        logic [1:0]  e_gnt;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    function automatic vec_t mk(logic [3:0] v, logic [31:0] d, logic [3:0] l, logic rdy,
                                logic e_txv, logic [7:0] e_txd, logic [3:0] e_rr,
                                logic e_busy, logic [1:0] e_gnt);
        vec_t r;
        r.v = v; r.d = d; r.l = l; r.rdy = rdy;
        r.e_txv = e_txv; r.e_txd = e_txd; r.e_rr = e_rr; r.e_busy = e_busy; r.e_gnt = e_gnt;
        return r;
    endfunction

    task automatic apply_range(input int first, input int last_i);
        for (int i = first; i <= last_i; i++) begin
            req_valid = vecs[i].v;
            req_data  = vecs[i].d;
            req_last  = vecs[i].l;
            tx_ready  = vecs[i].rdy;
            @(negedge CLK);
            chk($sformatf("vec%0d tx_valid", i), 32'(tx_valid), 32'(vecs[i].e_txv));
            chk($sformatf("vec%0d tx_data", i), 32'(tx_data), 32'(vecs[i].e_txd));
            chk($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(vecs[i].e_rr));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
            chk($sformatf("vec%0d grant_id", i), 32'(grant_id), 32'(vecs[i].e_gnt));
            tick();
        end
    endtask

    initial begin
        int n;
        int bad;

        // Single requester 2: 0x41,0x42,0x43 (last on 0x43).
        vecs[0]  = mk(4'b0100, 32'h0041_0000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
        vecs[1]  = mk(4'b0100, 32'h0041_0000, 4'b0000, 1'b1, 1'b1, 8'h41, 4'b0100, 1'b1, 2'd2);
        vecs[2]  = mk(4'b0100, 32'h0042_0000, 4'b0000, 1'b1, 1'b1, 8'h42, 4'b0100, 1'b1, 2'd2);
        vecs[3]  = mk(4'b0100, 32'h0043_0000, 4'b0100, 1'b1, 1'b1, 8'h43, 4'b0100, 1'b1, 2'd2);
        vecs[4]  = mk(4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2);
        // Round-robin among 0,1,3 with 1-byte messages, from reset.
        vecs[5]  = mk(4'b1011, 32'h1312_1110, 4'b1011, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
        vecs[6]  = mk(4'b1011, 32'h1312_1110, 4'b1011, 1'b1, 1'b1, 8'h10, 4'b0001, 1'b1, 2'd0);
        vecs[7]  = mk(4'b1011, 32'h1312_1110, 4'b1011, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
        vecs[8]  = mk(4'b1011, 32'h1312_1110, 4'b1011, 1'b1, 1'b1, 8'h11, 4'b0010, 1'b1, 2'd1);
        vecs[9]  = mk(4'b1011, 32'h1312_1110, 4'b1011, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1);
        vecs[10] = mk(4'b1011, 32'h1312_1110, 4'b1011, 1'b1, 1'b1, 8'h13, 4'b1000, 1'b1, 2'd3);
        vecs[11] = mk(4'b1011, 32'h1312_1110, 4'b1011, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd3);
        vecs[12] = mk(4'b1011, 32'h1312_1110, 4'b1011, 1'b1, 1'b1, 8'h10, 4'b0001, 1'b1, 2'd0);

        // Reset state.
        RST_N = 1'b0;
        #12;
        chk("rst tx_valid", 32'(tx_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst grant_id", 32'(grant_id), 32'd0);
        chk("rst req_ready", 32'(req_ready), 32'd0);
        chk("rst tx_data", 32'(tx_data), 32'd0);
        do_reset();

        apply_range(0, 4);
        do_reset();
        apply_range(5, 12);

        // Backpressure: tx_ready low for 5 cycles on the second byte.
        do_reset();
        sent_q.delete();
        req_valid = 4'b0010; req_data = 32'h0000_A100; req_last = '0; tx_ready = 1'b1;
        tick();
        tick();
        req_data = 32'h0000_A200; tx_ready = 1'b0;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            if (!tx_valid || tx_data !== 8'hA2 || req_ready !== 4'b0000 || !busy) bad++;
            tick();
        end
        chk("bp stall cycles bad", 32'(bad), 32'd0);
        tx_ready = 1'b1;
        @(negedge CLK);
        chk("bp ready resumes", 32'(req_ready), 32'b0010);
        tick();
        req_data = 32'h0000_A300; req_last = 4'b0010;
        tick();
        req_valid = '0; req_last = '0;
        @(negedge CLK);
        chk("bp busy after last", 32'(busy), 32'd0);
        chk("bp byte count", 32'(sent_q.size()), 32'd3);
        if (sent_q.size() == 3)
            chk("bp byte order", {8'h00, sent_q[0], sent_q[1], sent_q[2]}, 32'h00A1_A2A3);
        tick();

        // Timeout: req 1 sends one byte without last, then drops valid.
        do_reset();
        req_valid = 4'b0010; req_data = 32'h0000_5500; req_last = '0; tx_ready = 1'b1;
        tick();
        tick();
        req_valid = 4'b0001; req_data = 32'h0000_0077;
        n = 0;
`ifdef UART_ARB_TIMEOUT_EN
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            if (!busy) break;
            n++;
            tick();
        end
        chk("timeout busy cycles", 32'(n), 32'(LT));
        tick();
        @(negedge CLK);
        chk("timeout next busy", 32'(busy), 32'd1);
        chk("timeout next grant", 32'(grant_id), 32'd0);
        tick();
`else
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (busy && grant_id == 2'd1) n++;
            tick();
        end
        chk("no-timeout grant kept", 32'(n), 32'd40);
`endif

        // Timeout hold: valid held with tx_ready low for 40 cycles.
        do_reset();
        req_valid = 4'b0010; req_data = 32'h0000_6600; req_last = 4'b0010; tx_ready = 1'b0;
        tick();
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (!busy || grant_id !== 2'd1 || !tx_valid || req_ready !== 4'b0000) bad++;
            tick();
        end
        chk("hold grant kept", 32'(bad), 32'd0);
        tx_ready = 1'b1;
        @(negedge CLK);
        chk("hold ready", 32'(req_ready), 32'b0010);
        chk("hold data", 32'(tx_data), 32'h66);
        tick();
        req_valid = '0; req_last = '0;
        @(negedge CLK);
        chk("hold released", 32'(busy), 32'd0);
        tick();

        // Reset mid-message on requester 2's second byte.
        do_reset();
        req_valid = 4'b0100; req_data = 32'h0071_0000; req_last = '0; tx_ready = 1'b1;
        tick();
        @(negedge CLK);
        chk("rmid first byte", 32'(tx_data), 32'h71);
        tick();
        req_data = 32'h0072_0000; tx_ready = 1'b0;
        #2;
        chk("rmid busy before", 32'(busy), 32'd1);
        RST_N = 1'b0;
        #1;
        chk("rmid async tx_valid", 32'(tx_valid), 32'd0);
        chk("rmid async busy", 32'(busy), 32'd0);
        chk("rmid async grant", 32'(grant_id), 32'd0);
        tick();
        RST_N = 1'b1;
        req_valid = 4'b0101; req_data = 32'h0072_0080; req_last = 4'b0101; tx_ready = 1'b1;
        tick();
        @(negedge CLK);
        chk("rmid regrant busy", 32'(busy), 32'd1);
        chk("rmid regrant id", 32'(grant_id), 32'd0);
        chk("rmid regrant data", 32'(tx_data), 32'h80);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single on-board UART transmit path (UART_tx, out to uart_rxd_out) between NUM_REQ byte-stream requesters, e.g. the fmrv32im core console, a debug monitor and a status reporter. Arbitration is round-robin and message-granular: a grant is held until the requester marks the last byte, so messages never interleave. Sits between the requesters and the UART transmitter inside the ArtyA7 design, in the CLK100MHZ domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width
LOCK_TIMEOUT, 1024, idle cycles with no transfer after which a held grant is released (>=2)

Ports:
CLK  input  1  system clock (CLK100MHZ domain)
RST_N  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester byte valid
req_data  input  NUM_REQ*DATA_W  per-requester byte; requester i at [i*DATA_W +: DATA_W]
req_last  input  NUM_REQ  byte is last of message
req_ready  output  NUM_REQ  per-requester accept
tx_valid  output  1  byte valid to UART transmitter
tx_data  output  DATA_W  byte to UART transmitter
tx_ready  input  1  UART transmitter accepts byte
grant_id  output  $clog2(NUM_REQ)  currently granted requester
busy  output  1  grant held (state LOCK)

Behaviour:
- Reset (async, RST_N=0): state=IDLE, grant_id=0, last_grant=NUM_REQ-1, timeout counter=0. All outputs read 0: tx_valid, req_ready, busy, grant_id, tx_data.
- Handshake: a transfer occurs on the CLK edge where tx_valid && tx_ready. Holding rule: a requester must not drop valid, or change data/last, until it sees ready.
- IDLE:
  - tx_valid=0 and req_ready=0.
  - If any req_valid is set, pick the first set bit scanning from last_grant+1 upward, wrapping modulo NUM_REQ. Register it into grant_id and go to LOCK.
  - Arbitration latency is 1 cycle. The first byte can transfer in the cycle after the request is seen.
- LOCK (combinational passthrough of the granted requester g):
  - tx_valid=req_valid[g], tx_data=req_data[g], req_ready[g]=tx_ready, all other req_ready=0, busy=1.
  - A transfer with req_last[g]=1 sets last_grant=g and returns to IDLE. No back-to-back re-grant: IDLE always costs 1 cycle, and the just-served requester then has the lowest priority.
- Timeout: the counter clears on entry to LOCK and on every transfer, and increments in every other LOCK cycle. When it reaches LOCK_TIMEOUT-1 and req_valid[g]=0, go to IDLE with last_grant=g. A pending valid byte is never abandoned.
- Simultaneous events: a last-byte transfer and a timeout in the same cycle is treated as a normal completion. New requests that arrive during LOCK only wait, and are evaluated in IDLE.
- Reset mid-message: the message is abandoned immediately and the grant is lost. The requester must restart its message after reset.
- grant_id holds its value in IDLE and is only meaningful while busy=1.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined: the timeout counter and release logic exist as described.
- Undefined: no counter is instantiated. A grant is released only by a last-byte transfer or by reset, and LOCK_TIMEOUT is ignored.

Decomposition:
- Shared package uart_arb_pkg:
  - state typedef {IDLE, LOCK}
  - GRANT_W = $clog2(NUM_REQ) helper
  - default LOCK_TIMEOUT constant
- One natural sub-module, rr_pick: combinational round-robin first-set-bit finder. Inputs are the request vector and last_grant. Outputs are a found flag and an index.
- The FSM, counter and mux stay in uart_tx_arbiter.

Test Plan:
- Single requester: req 2 sends 3 bytes 0x41,0x42,0x43 with last on 0x43 and tx_ready=1. Required: grant_id=2, tx_data sequence 0x41,0x42,0x43 on consecutive cycles, then busy=0 the cycle after.
- Round-robin: reqs 0,1,3 all valid with 1-byte messages, starting from reset (last_grant=3). Required grant order 0,1,3,0; requester 2 is never granted.
- Backpressure: tx_ready=0 for 5 cycles mid-message. Required: tx_valid=1, tx_data stable and req_ready[g]=0 throughout, with no byte loss or duplication.
- Timeout (UART_ARB_TIMEOUT_EN, LOCK_TIMEOUT=16): req 1 sends 1 byte without last, then drops valid. Required: busy falls after 16 cycles and req 0 is then granted. Without the macro, busy stays 1 indefinitely.
- Timeout hold: req 1 holds valid with tx_ready=0 for 40 cycles at LOCK_TIMEOUT=16. Required: the grant is kept and the byte transfers when tx_ready=1.
- Reset mid-message: RST_N pulsed low during the second byte. Required: tx_valid=0, busy=0, grant_id=0 asynchronously, and the next grant after reset goes to requester 0.
